opb_swreg_bank: RTL and testbench

OPB_SWREG_BANK -- requirements
Module: opb_swreg_bank

---
 rtl/opb_swreg_pkg.sv | 21 ++
 rtl/opb_swreg_bank_if.sv | 28 ++
 rtl/opb_swreg_slave.sv | 69 ++++++
 rtl/opb_swreg_bank.sv | 130 +++++++++++++
 tb/tb_opb_swreg_bank.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/opb_swreg_pkg.sv
// Shared constants, FSM encoding and byte-lane helper for the OPB software register bank.
// Latency: none (declarations only).
// Backpressure: n/a.
package opb_swreg_pkg;

    localparam int CTRL_OFFSET = 16;
    localparam int COMMIT_BIT  = 0;
    localparam int PENDING_BIT = 31;
    localparam int MAX_REGS    = 16;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACK  = 1'b1
    } slv_state_t;

    // be[3] is OPB_BE[0], the lane carrying data bits 31:24
    function automatic logic [31:0] be_mask(input logic [3:0] be);
        return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction

endpackage

// File: rtl/opb_swreg_bank_if.sv
// OPB master/slave transfer signals, numeric bit order (bit 31 = OPB bit 0).
// Latency: none (wiring only).
// Backpressure: slave answers each select with one xfer_ack, never retries.
interface opb_swreg_bank_if;

    logic [31:0] abus;
    logic [3:0]  be;
    logic [31:0] dbus;
    logic        rnw;
    logic        select;
    logic        seq_addr;
    logic [31:0] sl_dbus;
    logic        xfer_ack;
    logic        err_ack;
    logic        retry;
    logic        tout_sup;

    modport master (
        output abus, be, dbus, rnw, select, seq_addr,
        input  sl_dbus, xfer_ack, err_ack, retry, tout_sup
    );

    modport slave (
        input  abus, be, dbus, rnw, select, seq_addr,
        output sl_dbus, xfer_ack, err_ack, retry, tout_sup
    );

endinterface

// File: rtl/opb_swreg_slave.sv
// OPB slave handshake: address decode, IDLE/ACK FSM, capture of the access and Sl_* drive.
// Latency: ack one cycle after the hit; write strobe to the register file during the ack cycle.
// Backpressure: none; every in-range select is acked, out-of-range ones are ignored.
module opb_swreg_slave
    import opb_swreg_pkg::*;
#(
    parameter logic [31:0] C_BASEADDR = 32'h01001000,
    parameter logic [31:0] C_HIGHADDR = 32'h010010FF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    opb_swreg_bank_if.slave      bus,
    output logic                 wr_vld,
    output logic [31:0]          acc_off,
    output logic [31:0]          wr_dat,
    output logic [3:0]           wr_be,
    input  logic [31:0]          rd_dat
);

    slv_state_t state, state_nxt;
    logic       hit;
    logic       rnw_q;
    logic       unused_seq;

    assign hit        = bus.select && (bus.abus >= C_BASEADDR) && (bus.abus <= C_HIGHADDR);
    assign unused_seq = bus.seq_addr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            acc_off <= '0;
            wr_dat  <= '0;
            wr_be   <= '0;
            rnw_q   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == ST_IDLE && hit) begin
                acc_off <= (bus.abus - C_BASEADDR) >> 2;
                wr_dat  <= bus.dbus;
                wr_be   <= bus.be;
                rnw_q   <= bus.rnw;
            end
        end
    end

    always_comb begin
        state_nxt    = state;
        bus.xfer_ack = 1'b0;
        bus.sl_dbus  = '0;
        wr_vld       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (hit) state_nxt = ST_ACK;
            end
            ST_ACK: begin
                state_nxt    = ST_IDLE;
                bus.xfer_ack = 1'b1;
                wr_vld       = !rnw_q;
                if (rnw_q) bus.sl_dbus = rd_dat;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign bus.err_ack  = 1'b0;
    assign bus.retry    = 1'b0;
    assign bus.tout_sup = 1'b0;

endmodule

// File: rtl/opb_swreg_bank.sv
// Bank of software-written registers on OPB, optionally shadowed behind a CTRL commit.
// Latency: register write at end of ack cycle; outputs and user_strobe change two cycles after the hit.
// Backpressure: none; user_strobe is a fire-and-forget single-cycle pulse.
module opb_swreg_bank
    import opb_swreg_pkg::*;
#(
    parameter logic [31:0] C_BASEADDR    = 32'h01001000,
    parameter logic [31:0] C_HIGHADDR    = 32'h010010FF,
    parameter int          C_NUM_REGS    = 4,
    parameter int          C_REG_WIDTH   = 32,
    parameter int          C_SHADOWED    = 1,
    parameter logic [31:0] C_RESET_VALUE = 32'h0
) (
    input  logic                              OPB_Clk,
    input  logic                              OPB_Rst_n,
    input  logic [0:31]                       OPB_ABus,
    input  logic [0:3]                        OPB_BE,
    input  logic [0:31]                       OPB_DBus,
    input  logic                              OPB_RNW,
    input  logic                              OPB_select,
    input  logic                              OPB_seqAddr,
    output logic [0:31]                       Sl_DBus,
    output logic                              Sl_xferAck,
    output logic                              Sl_errAck,
    output logic                              Sl_retry,
    output logic                              Sl_toutSup,
    output logic [C_NUM_REGS*C_REG_WIDTH-1:0] user_data_out,
    output logic [C_NUM_REGS-1:0]             user_strobe
);

    typedef logic [C_REG_WIDTH-1:0] reg_t;
    localparam reg_t RST_VAL = C_RESET_VALUE[C_REG_WIDTH-1:0];

    opb_swreg_bank_if bus ();

    // Port vectors are [0:31]; assignment keeps numeric value, so OPB bit 0 lands on bit 31
    assign bus.abus     = OPB_ABus;
    assign bus.be       = OPB_BE;
    assign bus.dbus     = OPB_DBus;
    assign bus.rnw      = OPB_RNW;
    assign bus.select   = OPB_select;
    assign bus.seq_addr = OPB_seqAddr;
    assign Sl_DBus      = bus.sl_dbus;
    assign Sl_xferAck   = bus.xfer_ack;
    assign Sl_errAck    = bus.err_ack;
    assign Sl_retry     = bus.retry;
    assign Sl_toutSup   = bus.tout_sup;

    logic        wr_vld;
    logic [31:0] acc_off;
    logic [31:0] wr_dat;
    logic [3:0]  wr_be;
    logic [31:0] rd_dat;

    opb_swreg_slave #(
        .C_BASEADDR (C_BASEADDR),
        .C_HIGHADDR (C_HIGHADDR)
    ) u_slave (
        .clk     (OPB_Clk),
        .rst_n   (OPB_Rst_n),
        .bus     (bus),
        .wr_vld  (wr_vld),
        .acc_off (acc_off),
        .wr_dat  (wr_dat),
        .wr_be   (wr_be),
        .rd_dat  (rd_dat)
    );

    reg_t                  shadow_q [C_NUM_REGS];
    reg_t                  out_q    [C_NUM_REGS];
    logic [C_NUM_REGS-1:0] dirty_q;
    logic [31:0]           wr_mask;
    reg_t                  wr_dat_w;
    reg_t                  wr_mask_w;
    logic                  commit;
    logic                  unused_bits;

    assign wr_mask     = be_mask(wr_be);
    assign wr_dat_w    = wr_dat[C_REG_WIDTH-1:0];
    assign wr_mask_w   = wr_mask[C_REG_WIDTH-1:0];
    assign unused_bits = ^{wr_dat, wr_mask};
    assign commit      = (C_SHADOWED != 0) && wr_vld && (acc_off == 32'(CTRL_OFFSET))
                         && wr_be[0] && wr_dat[COMMIT_BIT];

    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) begin
            for (int i = 0; i < C_NUM_REGS; i++) begin
                shadow_q[i] <= RST_VAL;
                out_q[i]    <= RST_VAL;
            end
            dirty_q     <= '0;
            user_strobe <= '0;
        end else begin
            user_strobe <= '0;
            for (int i = 0; i < C_NUM_REGS; i++) begin
                if (wr_vld && (acc_off == 32'(i))) begin
                    if (C_SHADOWED != 0) begin
                        shadow_q[i] <= (shadow_q[i] & ~wr_mask_w) | (wr_dat_w & wr_mask_w);
                        dirty_q[i]  <= 1'b1;
                    end else begin
                        out_q[i]       <= (out_q[i] & ~wr_mask_w) | (wr_dat_w & wr_mask_w);
                        user_strobe[i] <= 1'b1;
                    end
                end
                // A commit and a register write never share a cycle: they target different offsets
                if (commit && dirty_q[i]) begin
                    out_q[i]       <= shadow_q[i];
                    user_strobe[i] <= 1'b1;
                    dirty_q[i]     <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        rd_dat = '0;
        for (int i = 0; i < C_NUM_REGS; i++) begin
            if (acc_off == 32'(i)) rd_dat = 32'((C_SHADOWED != 0) ? shadow_q[i] : out_q[i]);
        end
        if ((C_SHADOWED != 0) && (acc_off == 32'(CTRL_OFFSET))) begin
            rd_dat[PENDING_BIT]    = |dirty_q;
            rd_dat[C_NUM_REGS-1:0] = dirty_q;
        end
    end

    for (genvar g = 0; g < C_NUM_REGS; g++) begin : g_out
        assign user_data_out[g*C_REG_WIDTH +: C_REG_WIDTH] = out_q[g];
    end

endmodule

// File: tb/tb_opb_swreg_bank.sv
// Directed bench: a default shadowed 32-bit bank and a 12-bit unshadowed bank with a non-zero reset value.
module tb_opb_swreg_bank;

    localparam logic [31:0] BASE = 32'h01001000;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    opb_swreg_bank_if m0 ();
    opb_swreg_bank_if m1 ();

    logic [127:0] uout0;
    logic [47:0]  uout1;
    logic [3:0]   strb0, strb1;

    opb_swreg_bank dut0 (
        .OPB_Clk(clk), .OPB_Rst_n(rst_n),
        .OPB_ABus(m0.abus), .OPB_BE(m0.be), .OPB_DBus(m0.dbus), .OPB_RNW(m0.rnw),
        .OPB_select(m0.select), .OPB_seqAddr(m0.seq_addr),
        .Sl_DBus(m0.sl_dbus), .Sl_xferAck(m0.xfer_ack), .Sl_errAck(m0.err_ack),
        .Sl_retry(m0.retry), .Sl_toutSup(m0.tout_sup),
        .user_data_out(uout0), .user_strobe(strb0)
    );

    opb_swreg_bank #(
        .C_NUM_REGS(4), .C_REG_WIDTH(12), .C_SHADOWED(0), .C_RESET_VALUE(32'h12345ABC)
    ) dut1 (
        .OPB_Clk(clk), .OPB_Rst_n(rst_n),
        .OPB_ABus(m1.abus), .OPB_BE(m1.be), .OPB_DBus(m1.dbus), .OPB_RNW(m1.rnw),
        .OPB_select(m1.select), .OPB_seqAddr(m1.seq_addr),
        .Sl_DBus(m1.sl_dbus), .Sl_xferAck(m1.xfer_ack), .Sl_errAck(m1.err_ack),
        .Sl_retry(m1.retry), .Sl_toutSup(m1.tout_sup),
        .user_data_out(uout1), .user_strobe(strb1)
    );

    function automatic logic [31:0] addr(input int off);
        return BASE + 32'(off) * 4;
    endfunction

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input int d, input logic sel, input logic [31:0] a, input logic [3:0] be,
                         input logic [31:0] dat, input logic rnw);
        if (d == 0) begin
            m0.select = sel; m0.abus = a; m0.be = be; m0.dbus = dat; m0.rnw = rnw; m0.seq_addr = 1'b0;
        end else begin
            m1.select = sel; m1.abus = a; m1.be = be; m1.dbus = dat; m1.rnw = rnw; m1.seq_addr = 1'b0;
        end
    endtask

    // Returns with select dropped, just after the edge that starts cycle T+2
    task automatic xfer(input int d, input logic [31:0] a, input logic [3:0] be, input logic [31:0] dat,
                        input logic rnw, output logic [31:0] rdat, output int lat);
        @(posedge clk); #1;
        drive(d, 1'b1, a, be, dat, rnw);
        lat  = -1;
        rdat = '0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if ((d == 0 ? m0.xfer_ack : m1.xfer_ack) === 1'b1) begin
                lat  = c;
                rdat = (d == 0) ? m0.sl_dbus : m1.sl_dbus;
                break;
            end
        end
        @(posedge clk); #1;
        drive(d, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0);
    endtask

    task automatic wr(input int d, input int off, input logic [3:0] be, input logic [31:0] dat, input string tag);
        logic [31:0] r;
        int          lat;
        xfer(d, addr(off), be, dat, 1'b0, r, lat);
        check({tag, "_lat"}, lat, 1);
    endtask

    task automatic rd(input int d, input int off, input logic [31:0] exp, input string tag);
        logic [31:0] r;
        int          lat;
        xfer(d, addr(off), 4'hF, 32'h0, 1'b1, r, lat);
        check({tag, "_lat"}, lat, 1);
        check(tag, r, exp);
    endtask

    initial begin
        logic [31:0] r, d1, d3;
        int          lat;
        logic        a0, a1, a2, a3;

        rst_n = 1'b0;
        drive(0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0);
        drive(1, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ack0", m0.xfer_ack, 0);
        check("rst_dbus0", m0.sl_dbus, 0);
        check("rst_uout0", uout0, 0);
        check("rst_strb0", strb0, 0);
        check("rst_uout1", uout1, 48'hABC_ABC_ABC_ABC);
        check("tied_zero", {m0.err_ack, m0.retry, m0.tout_sup, m1.err_ack, m1.retry, m1.tout_sup}, 0);
        rst_n = 1'b1;

        // Shadowed write stays invisible until commit
        wr(0, 1, 4'hF, 32'hDEADBEEF, "wr_reg1");
        @(negedge clk);
        check("shadow_hold", uout0, 0);
        check("shadow_nostrb", strb0, 0);
        rd(0, 16, 32'h80000002, "ctrl_dirty1");
        rd(0, 1, 32'hDEADBEEF, "rd_shadow1");

        wr(0, 16, 4'hF, 32'h1, "commit1");
        @(negedge clk);
        check("commit1_strb", strb0, 4'b0010);
        check("commit1_uout", uout0, {32'h0, 32'h0, 32'hDEADBEEF, 32'h0});
        @(negedge clk);
        check("commit1_strb_end", strb0, 0);

        wr(0, 0, 4'hF, 32'h11223344, "wr_reg0");
        wr(0, 2, 4'hF, 32'h55667788, "wr_reg2");
        wr(0, 16, 4'hF, 32'h1, "commit2");
        @(negedge clk);
        check("commit2_strb", strb0, 4'b0101);
        check("commit2_uout", uout0, {32'h0, 32'h55667788, 32'hDEADBEEF, 32'h11223344});
        @(negedge clk);
        check("commit2_strb_end", strb0, 0);
        rd(0, 16, 32'h0, "ctrl_clean");

        wr(0, 16, 4'hF, 32'h1, "commit_empty");
        @(negedge clk);
        check("empty_strb", strb0, 0);
        check("empty_uout", uout0, {32'h0, 32'h55667788, 32'hDEADBEEF, 32'h11223344});

        wr(0, 0, 4'b0100, 32'hAABBCCDD, "be_wr");
        rd(0, 0, 32'h11BB3344, "be_rd");

        // Commit bit without the low byte lane enabled is not a commit
        wr(0, 16, 4'b1110, 32'h1, "commit_nobe");
        @(negedge clk);
        check("nobe_strb", strb0, 0);
        rd(0, 16, 32'h80000001, "ctrl_dirty0");

        rd(0, 5, 32'h0, "hole_rd");
        wr(0, 7, 4'hF, 32'hFFFFFFFF, "hole_wr");
        rd(0, 16, 32'h80000001, "hole_wr_noeffect");
        xfer(0, BASE + 32'h100, 4'hF, 32'h0, 1'b1, r, lat);
        check("oob_high_noack", lat, -1);
        xfer(0, BASE - 32'h4, 4'hF, 32'h0, 1'b1, r, lat);
        check("oob_low_noack", lat, -1);

        // Unshadowed 12-bit bank
        wr(1, 1, 4'hF, 32'hFFFFFFFF, "w12_wr");
        @(negedge clk);
        check("w12_strb", strb1, 4'b0010);
        check("w12_uout", uout1, 48'hABC_ABC_FFF_ABC);
        @(negedge clk);
        check("w12_strb_end", strb1, 0);
        rd(1, 1, 32'h00000FFF, "w12_rd");
        rd(1, 5, 32'h0, "idx5_rd");
        rd(1, 16, 32'h0, "ctrl_unshadowed");
        wr(1, 16, 4'hF, 32'h1, "commit_unshadowed");
        @(negedge clk);
        check("unshadowed_nostrb", strb1, 0);
        wr(1, 2, 4'b0001, 32'h00000123, "w12_be");
        rd(1, 2, 32'h00000A23, "w12_be_rd");

        // Back-to-back reads with select held high
        @(posedge clk); #1;
        drive(1, 1'b1, addr(1), 4'hF, 32'h0, 1'b1);
        @(negedge clk); a0 = m1.xfer_ack;
        @(negedge clk); a1 = m1.xfer_ack; d1 = m1.sl_dbus;
        @(posedge clk); #1;
        drive(1, 1'b1, addr(2), 4'hF, 32'h0, 1'b1);
        @(negedge clk); a2 = m1.xfer_ack;
        @(negedge clk); a3 = m1.xfer_ack; d3 = m1.sl_dbus;
        @(posedge clk); #1;
        drive(1, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0);
        check("b2b_ack_pattern", {a0, a1, a2, a3}, 4'b0101);
        check("b2b_d1", d1, 32'h00000FFF);
        check("b2b_d3", d3, 32'h00000A23);

        // Reset asserted in the middle of an ack cycle
        @(posedge clk); #1;
        drive(0, 1'b1, addr(2), 4'hF, 32'h00000999, 1'b0);
        @(negedge clk);
        @(negedge clk);
        check("rst_pre_ack", m0.xfer_ack, 1);
        rst_n = 1'b0;
        #1;
        check("rst_ack_drop", m0.xfer_ack, 0);
        check("rst_dbus_zero", m0.sl_dbus, 0);
        check("rst_uout0_mid", uout0, 0);
        check("rst_strb0_mid", strb0, 0);
        check("rst_uout1_mid", uout1, 48'hABC_ABC_ABC_ABC);
        drive(0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        rd(0, 2, 32'h0, "rst_no_write");
        rd(0, 16, 32'h0, "rst_dirty_clear");
        rd(0, 1, 32'h0, "rst_shadow_clear");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
